// File: rtl/myproject_div_pkg.sv
// Shared widths, FSM states and the quotient saturation helper for the
// signed sequential divider.
package myproject_div_pkg;

    localparam int DIV_N_W = 26;
    localparam int DIV_D_W = 10;
    localparam int DIV_Q_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } div_state_t;

    localparam logic signed [DIV_Q_W-1:0] QMAX = {1'b0, {(DIV_Q_W-1){1'b1}}};
    localparam logic signed [DIV_Q_W-1:0] QMIN = {1'b1, {(DIV_Q_W-1){1'b0}}};

    // Limits widened to the signed magnitude domain (dividend width + sign).
    localparam logic signed [DIV_N_W:0] QMAX_X = (DIV_N_W+1)'(QMAX);
    localparam logic signed [DIV_N_W:0] QMIN_X = (DIV_N_W+1)'(QMIN);

    typedef struct packed {
        logic               ovf;
        logic [DIV_Q_W-1:0] q;
    } sat_t;

    function automatic sat_t sat_q(input logic signed [DIV_N_W:0] v);
        sat_t s;
        s.ovf = 1'b0;
        s.q   = v[DIV_Q_W-1:0];
        if (v > QMAX_X) begin
            s.ovf = 1'b1;
            s.q   = QMAX;
        end else if (v < QMIN_X) begin
            s.ovf = 1'b1;
            s.q   = QMIN;
        end
        return s;
    endfunction

endpackage

// File: rtl/myproject_udiv_iter_26u_10u.sv
// Unsigned restoring division core: one quotient bit per step, MSB first.
// The dividend shift register doubles as the quotient register.
module myproject_udiv_iter_26u_10u
    import myproject_div_pkg::*;
#(
    parameter int N_W = DIV_N_W,
    parameter int D_W = DIV_D_W
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           load,
    input  logic           step,
    input  logic [N_W-1:0] dividend,
    input  logic [D_W-1:0] divisor,
    output logic [N_W-1:0] quo,
    output logic [D_W-1:0] rem
);

    logic [N_W-1:0] q_r;
    logic [D_W:0]   r_r;
    logic [D_W-1:0] d_r;
    logic [D_W:0]   trial;
    logic [D_W:0]   diff;
    logic           fits;

    always_comb begin
        trial = {r_r[D_W-1:0], q_r[N_W-1]};
        diff  = trial - {1'b0, d_r};
        fits  = (trial >= {1'b0, d_r});
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_r <= '0;
            r_r <= '0;
            d_r <= '0;
        end else if (load) begin
            q_r <= dividend;
            r_r <= '0;
            d_r <= divisor;
        end else if (step) begin
            q_r <= {q_r[N_W-2:0], fits};
            r_r <= fits ? diff : trial;
        end
    end

    assign quo = q_r;
    // Partial remainder is always below the divisor after a step, so its MSB is zero.
    assign rem = r_r[D_W-1:0];

endmodule

// File: rtl/myproject_sdiv_26s_10s_16_seq.sv
// Signed sequential divider: start/done handshake, fixed latency, ce stall,
// quotient truncated toward zero and saturated, remainder signed like dividend.
module myproject_sdiv_26s_10s_16_seq
    import myproject_div_pkg::*;
#(
    parameter int din0_WIDTH = DIV_N_W,
    parameter int din1_WIDTH = DIV_D_W,
    parameter int dout_WIDTH = DIV_Q_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  start,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  ready,
    output logic                  done,
    output logic [dout_WIDTH-1:0] dout,
    output logic [din1_WIDTH-1:0] rem,
    output logic                  ovf,
    output logic                  dbz
);

    localparam int CNT_W = $clog2(din0_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(din0_WIDTH - 1);

    div_state_t state, state_nxt;

    logic [CNT_W-1:0]      cnt;
    logic                  qneg;
    logic                  nneg;
    logic                  dzero;
    logic                  accept;
    logic                  core_step;
    logic [din0_WIDTH-1:0] n_mag;
    logic [din1_WIDTH-1:0] d_mag;
    logic [din0_WIDTH-1:0] q_mag;
    logic [din1_WIDTH-1:0] r_mag;

    logic [din0_WIDTH:0]          q_ext;
    logic signed [din0_WIDTH:0]   q_sgn;
    sat_t                         q_sat;
    logic [din1_WIDTH-1:0]        r_fix;
    logic [dout_WIDTH-1:0]        q_fix;
    logic                         ovf_fix;

    assign accept    = ce && (state == IDLE) && start;
    assign core_step = ce && (state == CALC);
    assign n_mag     = din0[din0_WIDTH-1] ? -din0 : din0;
    assign d_mag     = din1[din1_WIDTH-1] ? -din1 : din1;

    myproject_udiv_iter_26u_10u #(
        .N_W (din0_WIDTH),
        .D_W (din1_WIDTH)
    ) u_core (
        .clk      (clk),
        .reset    (reset),
        .load     (accept),
        .step     (core_step),
        .dividend (n_mag),
        .divisor  (d_mag),
        .quo      (q_mag),
        .rem      (r_mag)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else if (ce) begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = CALC;
            CALC: if (cnt == CNT_LAST) state_nxt = FIX;
            FIX:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Sign application and saturation of the finished magnitudes.
    always_comb begin
        q_ext   = {1'b0, q_mag};
        q_sgn   = qneg ? -q_ext : q_ext;
        q_sat   = sat_q(q_sgn);
        r_fix   = nneg ? -r_mag : r_mag;
        q_fix   = q_sat.q;
        ovf_fix = q_sat.ovf;
        if (dzero) begin
            q_fix   = nneg ? QMIN : QMAX;
            r_fix   = '0;
            ovf_fix = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            qneg  <= 1'b0;
            nneg  <= 1'b0;
            dzero <= 1'b0;
            done  <= 1'b0;
            dout  <= '0;
            rem   <= '0;
            ovf   <= 1'b0;
            dbz   <= 1'b0;
        end else if (ce) begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt   <= '0;
                        qneg  <= din0[din0_WIDTH-1] ^ din1[din1_WIDTH-1];
                        nneg  <= din0[din0_WIDTH-1];
                        dzero <= (din1 == '0);
                    end
                end
                CALC: cnt <= cnt + 1'b1;
                FIX: begin
                    done <= 1'b1;
                    dout <= q_fix;
                    rem  <= r_fix;
                    ovf  <= ovf_fix;
                    dbz  <= dzero;
                end
                default: ;
            endcase
        end
    end

    assign ready = (state == IDLE);

endmodule

// File: tb/tb_myproject_sdiv_26s_10s_16_seq.sv
// Randomised and directed checks of the signed divider against a plain
// integer-arithmetic reference (C-style truncating / and %).
module tb_myproject_sdiv_26s_10s_16_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        ce;
    logic        start;
    logic [25:0] din0;
    logic [9:0]  din1;
    logic        ready;
    logic        done;
    logic [15:0] dout;
    logic [9:0]  rem;
    logic        ovf;
    logic        dbz;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    myproject_sdiv_26s_10s_16_seq dut (
        .clk   (clk),
        .reset (reset),
        .ce    (ce),
        .start (start),
        .din0  (din0),
        .din1  (din1),
        .ready (ready),
        .done  (done),
        .dout  (dout),
        .rem   (rem),
        .ovf   (ovf),
        .dbz   (dbz)
    );

    task automatic chk(input string tag, input longint got, input longint exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_result(input string tag, input longint n, input longint d);
        longint eq, er, eovf, edbz, q;
        if (d == 0) begin
            eq   = (n >= 0) ? 32767 : -32768;
            er   = 0;
            eovf = 1;
            edbz = 1;
        end else begin
            q    = n / d;
            er   = n % d;
            edbz = 0;
            eovf = (q > 32767 || q < -32768) ? 1 : 0;
            eq   = (q > 32767) ? 32767 : (q < -32768) ? -32768 : q;
        end
        chk({tag, ".dout"}, longint'($signed(dout)), eq);
        chk({tag, ".rem"},  longint'($signed(rem)),  er);
        chk({tag, ".ovf"},  longint'(ovf),  eovf);
        chk({tag, ".dbz"},  longint'(dbz),  edbz);
    endtask

    // Counts cycles from the accepting edge to the first cycle with done high.
    task automatic wait_done(input string tag, input int stall_at, input int stall_len,
                             output int cycles);
        cycles = 0;
        do begin
            tick();
            cycles++;
            if (cycles == stall_at) ce = 1'b0;
            if (cycles == stall_at + stall_len) ce = 1'b1;
        end while (!done && cycles < 200);
        ce = 1'b1;
        if (!done) chk({tag, ".timeout"}, 0, 1);
    endtask

    task automatic do_op(input string tag, input longint n, input longint d,
                         input int stall_at, input int stall_len);
        int cyc;
        din0  = n[25:0];
        din1  = d[9:0];
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, ".busy"}, longint'(ready), 0);
        wait_done(tag, stall_at, stall_len, cyc);
        chk({tag, ".lat"}, cyc, 27 + stall_len);
        expect_result(tag, n, d);
        tick();
        chk({tag, ".pulse"}, longint'(done), 0);
    endtask

    initial begin
        int cyc;
        int ndone;
        logic signed [25:0] rn;
        logic signed [9:0]  rd;

        reset = 1'b1;
        ce    = 1'b1;
        start = 1'b0;
        din0  = '0;
        din1  = '0;
        repeat (3) tick();
        reset = 1'b0;
        chk("rst.ready", longint'(ready), 1);
        chk("rst.done",  longint'(done), 0);
        chk("rst.dout",  longint'(dout), 0);
        chk("rst.rem",   longint'(rem), 0);
        chk("rst.ovf",   longint'(ovf), 0);
        chk("rst.dbz",   longint'(dbz), 0);

        do_op("d1000_7",  1000, 7, 0, 0);
        do_op("dn1000_7", -1000, 7, 0, 0);
        do_op("d1000_n7", 1000, -7, 0, 0);
        do_op("dnn",      -1000, -7, 0, 0);
        do_op("dn7_2",    -7, 2, 0, 0);
        do_op("ovf_pmax", 33554431, 1, 0, 0);
        do_op("ovf_nn",   -33554432, -1, 0, 0);
        do_op("ovf_np",   -33554432, 1, 0, 0);
        do_op("dbz_neg",  -5, 0, 0, 0);
        do_op("dbz_pos",  5, 0, 0, 0);
        do_op("dmin_div", 1000, -512, 0, 0);

        // Stall mid-CALC for 5 cycles, then freeze the done cycle once.
        din0  = 26'd1000;
        din1  = 10'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("stall", 10, 5, cyc);
        chk("stall.lat", cyc, 32);
        expect_result("stall", 1000, 7);
        ce = 1'b0;
        tick();
        chk("stall.hold_done", longint'(done), 1);
        expect_result("stall_hold", 1000, 7);
        ce = 1'b1;
        tick();
        chk("stall.done_fall", longint'(done), 0);

        // Starts while busy must be ignored.
        din0  = 26'd2000;
        din1  = 10'd9;
        start = 1'b1;
        tick();
        start = 1'b0;
        ndone = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (done) ndone++;
            if (i == 5 || i == 12 || i == 20) begin
                start = 1'b1;
                din0  = 26'd77;
                din1  = 10'd3;
            end else begin
                start = 1'b0;
            end
        end
        chk("busy.ndone", ndone, 1);
        expect_result("busy", 2000, 9);
        chk("busy.ready", longint'(ready), 1);

        // Reset mid-CALC abandons the operation.
        din0  = 26'd1000;
        din1  = 10'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (11) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mrst.dout",  longint'(dout), 0);
        chk("mrst.rem",   longint'(rem), 0);
        chk("mrst.ovf",   longint'(ovf), 0);
        chk("mrst.dbz",   longint'(dbz), 0);
        chk("mrst.ready", longint'(ready), 1);
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done) ndone++;
        end
        chk("mrst.ndone", ndone, 0);
        do_op("d100_3", 100, 3, 0, 0);

        // Back-to-back: start raised in the done cycle.
        din0  = 26'd500;
        din1  = 10'd11;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("b2b_a", 0, 0, cyc);
        expect_result("b2b_a", 500, 11);
        din0  = -26'sd300;
        din1  = 10'd13;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("b2b.accept", longint'(ready), 0);
        wait_done("b2b_b", 0, 0, cyc);
        chk("b2b.lat", cyc, 27);
        expect_result("b2b_b", -300, 13);
        tick();

        for (int k = 0; k < 30; k++) begin
            rn = 26'($urandom);
            rd = 10'($urandom);
            if (k % 3 == 0) rn = 26'($signed(10'($urandom)) * 7);
            if (k % 10 == 5) rd = '0;
            do_op($sformatf("rnd%0d", k), longint'(rn), longint'(rd),
                  int'($urandom_range(1, 20)), int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
